// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler
//   Picks which warp's head instruction leaves the per-warp instruction buffer
//   each cycle. The candidates are warps that have a buffered instruction and
//   are not stalled. Arbitration is round-robin. A warp whose age counter has
//   saturated at STARVE_LIMIT takes priority over round-robin. The grant is
//   registered and handed to issue with a valid/ready handshake.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   req_valid      [NUM_WARPS]  per-warp buffer non-empty
//   req_stall      [NUM_WARPS]  per-warp stall (hazard / barrier / fence)
//   issue_valid    registered grant valid
//   issue_wid      [NW_BITS]    registered granted warp index
//   issue_ready    issue stage accepts the grant
//   starve_active  the current grant was chosen by the starvation override
//
// Optional feature (macro ISSUE_SCHED_PERF_EN)
//   perf_issued    [32] number of fires
//   perf_idle      [32] cycles in which no warp was eligible
//   perf_starve    [32] fires of starvation-chosen grants
//   All three counters wrap modulo 2^32. Arbitration is the same in both builds.

module warp_issue_scheduler #(
    parameter int NUM_WARPS    = 4,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int STARVE_LIMIT = 8,
    parameter int AGE_BITS     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] req_valid,
    input  logic [NUM_WARPS-1:0] req_stall,
    output logic                 issue_valid,
    output logic [NW_BITS-1:0]   issue_wid,
    input  logic                 issue_ready,
    output logic                 starve_active
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_idle,
    output logic [31:0]          perf_starve
`endif
);

    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(STARVE_LIMIT);

    logic [NUM_WARPS-1:0] eligible;
    logic                 fire;
    logic                 reselect;
    logic [NW_BITS-1:0]   rr_ptr;
    logic [AGE_BITS-1:0]  age [NUM_WARPS];

    logic                 sel_valid;
    logic [NW_BITS-1:0]   sel_wid;
    logic                 sel_starve;
    logic [NW_BITS-1:0]   rr_base;
    logic [NW_BITS-1:0]   rr_idx;

    assign eligible = req_valid & ~req_stall;
    assign fire     = issue_valid & issue_ready;
    assign reselect = ~issue_valid | fire;

    // If a grant fires this cycle, the round-robin search starts just after that
    // warp, so the pointer update and the next pick agree.
    assign rr_base = fire ? issue_wid : rr_ptr;

    always_comb begin
        // NOTE: every output of this block gets a default first. Otherwise a path
        // that assigns nothing would infer a latch.
        sel_valid  = 1'b0;
        sel_wid    = '0;
        sel_starve = 1'b0;
        rr_idx     = '0;

        // Starvation override: the lowest-index starved warp wins. A warp that
        // is firing now is left out even if its age has saturated. Its age
        // clears on this fire, and it may be granted again only through
        // round-robin.
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (eligible[i] && (age[i] == AGE_MAX) &&
                !(fire && (issue_wid == NW_BITS'(i)))) begin
                sel_valid  = 1'b1;
                sel_wid    = NW_BITS'(i);
                sel_starve = 1'b1;
            end
        end

        // Round-robin: search downward so the last hit is the smallest offset
        // after rr_base. Offset NUM_WARPS truncates to 0, which gives rr_base
        // itself. That is the lowest priority, so the fired warp repeats only
        // when it is the only warp eligible.
        if (!sel_starve) begin
            for (int k = NUM_WARPS; k >= 1; k--) begin
                rr_idx = rr_base + NW_BITS'(k);
                if (eligible[rr_idx]) begin
                    sel_valid = 1'b1;
                    sel_wid   = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid   <= 1'b0;
            issue_wid     <= '0;
            starve_active <= 1'b0;
            rr_ptr        <= NW_BITS'(NUM_WARPS - 1);
            // NOTE: the age array is only NUM_WARPS small flops, not a RAM.
            // It is reset with the rest of the state so that starvation starts
            // from a known point.
            for (int i = 0; i < NUM_WARPS; i++) age[i] <= '0;
        end else begin
            // While the grant is held (valid && !ready), wid and starve_active stay
            // frozen. A stall that rises on the held warp does not revoke it.
            if (reselect) begin
                issue_valid   <= sel_valid;
                starve_active <= sel_valid & sel_starve;
                if (sel_valid) issue_wid <= sel_wid;
            end
            if (fire) rr_ptr <= issue_wid;

            for (int i = 0; i < NUM_WARPS; i++) begin
                if ((fire && (issue_wid == NW_BITS'(i))) || !eligible[i])
                    age[i] <= '0;
                else if (age[i] != AGE_MAX)
                    age[i] <= age[i] + AGE_BITS'(1);
            end
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued <= '0;
            perf_idle   <= '0;
            perf_starve <= '0;
        end else begin
            if (fire)                  perf_issued <= perf_issued + 32'd1;
            if (eligible == '0)        perf_idle   <= perf_idle + 32'd1;
            if (fire && starve_active) perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule
